cordic_arbiter: RTL and testbench
=================================

CORDIC_ARBITER -- requirements
Module: cordic_arbiter

Interface
REQ-001 Parameter ITERATIONS, default 8: number of RUN cycles the shared CORDIC core needs before its sin/cos outputs are valid.
REQ-002 Parameter WIDTH, default 8: width of angle and result buses.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST_N  input  1  synchronous, active-low reset, sampled on rising CLK.
REQ-005 REQ_A, REQ_B  input  1 each  requester A/B wants one sin/cos evaluation.
REQ-006 ANGLE_A, ANGLE_B  input  WIDTH each  requester angle, unsigned binary fraction of 90 deg; held stable while REQ_x high.
REQ-007 DONE_A, DONE_B  output  1 each  one-cycle pulse: result for requester x valid on SIN_OUT/COS_OUT.
REQ-008 SIN_OUT, COS_OUT  output  WIDTH each  registered results, signed, held until next capture.
REQ-009 BUSY  output  1  high whenever state is not IDLE.
REQ-010 CORE_ANGLE  output  WIDTH  angle driven to the CORDIC core, registered.
REQ-011 CORE_START  output  1  core run control: low clears the core, high lets it iterate.
REQ-012 CORE_SIN, CORE_COS  input  WIDTH each  core results, valid after ITERATIONS cycles of CORE_START high.

Function
REQ-013 The FSM SHALL have states IDLE, LOAD, RUN, CAPTURE, DONE, encoded in a single registered state variable.
REQ-014 IDLE: CORE_START=0; if REQ_A or REQ_B high, grant one requester, latch its ANGLE_x into CORE_ANGLE and a grant register, then go to LOAD; otherwise stay.
REQ-015 Arbitration SHALL be round-robin with a 1-bit priority pointer; a lone requester is always granted; on simultaneous REQ_A and REQ_B the pointed-to requester wins.
REQ-016 The pointer SHALL move to the non-granted requester in the DONE state.
REQ-017 REQ_x SHALL be sampled only in IDLE; requests arriving in any other state wait.
REQ-018 LOAD: CORE_START held 0 for exactly one cycle to clear the core; go to RUN.
REQ-019 RUN: CORE_START=1 and a counter of width clog2(ITERATIONS)+1 increments from 0; when it equals ITERATIONS-1, go to CAPTURE.
REQ-020 CAPTURE: CORE_START=1 (core still held); register CORE_SIN/CORE_COS into SIN_OUT/COS_OUT; go to DONE.
REQ-021 DONE: CORE_START=0; assert DONE_x for the granted requester only, for exactly this one cycle; clear counter; go to IDLE.
REQ-022 Latency: REQ sampled in IDLE at cycle 0, DONE_x high at cycle ITERATIONS+3; back-to-back service period SHALL be ITERATIONS+4 cycles.
REQ-023 If the granted REQ_x falls before DONE, the operation SHALL still complete and DONE_x SHALL still pulse.
REQ-024 CORE_ANGLE SHALL not change between LOAD and DONE inclusive, regardless of ANGLE_x changes.
REQ-025 DONE_A and DONE_B SHALL never be high in the same cycle.

Reset
REQ-026 On a rising CLK with RST_N=0: state=IDLE, pointer=A, counter=0, CORE_START=0, CORE_ANGLE=0, SIN_OUT=0, COS_OUT=0, DONE_A=DONE_B=0, BUSY=0.
REQ-027 Reset asserted in any state SHALL abort the operation with no DONE pulse; the first request after RST_N returns high is granted by the IDLE rules with pointer=A.

Verification
REQ-028 ITERATIONS=8; REQ_A=1, ANGLE_A=210 at cycle 0 -> CORE_ANGLE=210 from cycle 1, CORE_START high cycles 2-10, DONE_A pulse at cycle 11, SIN_OUT/COS_OUT equal core outputs sampled at cycle 10.
REQ-029 REQ_A and REQ_B both high from reset, ANGLE_A=210, ANGLE_B=94 -> DONE_A at cycle 11, B granted at cycle 12, DONE_B at cycle 23, CORE_ANGLE=94 from cycle 13.
REQ-030 Serve B alone (angle 94), then raise REQ_A and REQ_B together -> A granted first (pointer moved to A after B's DONE).
REQ-031 RST_N low for one cycle during RUN (cycle 5) -> CORE_START=0, BUSY=0, no DONE pulse on either line; a new REQ_A then gives DONE_A 11 cycles after its IDLE sample.
REQ-032 REQ_A dropped at cycle 4 and ANGLE_A changed to 17 -> CORE_ANGLE stays 210, DONE_A still pulses at cycle 11.
REQ-033 Continuous REQ_B only -> DONE_B every 12 cycles, BUSY low exactly one cycle between operations.

Source files
------------

// File: rtl/cordic_arbiter.sv
// -----------------------------------------------------------------------------
// cordic_arbiter
// Shares one iterative CORDIC sin/cos core between two requesters (A and B).
// A request seen in IDLE is granted round-robin. Its angle is latched and
// presented to the core, which is cleared for one cycle and then run for
// ITERATIONS cycles. The core results are captured, and a one-cycle DONE
// pulse goes back to the granted requester.
//
// Ports
//   clk_i          : sole clock, rising edge
//   rst_n_i        : synchronous active-low reset
//   req_a_i/req_b_i: requester A/B wants one sin/cos evaluation
//   angle_a_i/_b_i : requester angle, unsigned fraction of 90 deg
//   done_a_o/_b_o  : one-cycle pulse, result for that requester is valid
//   sin_out_o      : captured sine (two's complement), held until next capture
//   cos_out_o      : captured cosine (two's complement), held until next capture
//   busy_o         : high whenever the FSM is not idle
//   core_angle_o   : registered angle driven to the CORDIC core
//   core_start_o   : core run control (0 clears the core, 1 iterates)
//   core_sin_i/_cos_i : core results, valid after ITERATIONS run cycles
// -----------------------------------------------------------------------------
module cordic_arbiter #(
  parameter int ITERATIONS = 8,
  parameter int WIDTH      = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             req_a_i,
  input  logic             req_b_i,
  input  logic [WIDTH-1:0] angle_a_i,
  input  logic [WIDTH-1:0] angle_b_i,
  output logic             done_a_o,
  output logic             done_b_o,
  output logic [WIDTH-1:0] sin_out_o,
  output logic [WIDTH-1:0] cos_out_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] core_angle_o,
  output logic             core_start_o,
  input  logic [WIDTH-1:0] core_sin_i,
  input  logic [WIDTH-1:0] core_cos_i
);

  localparam int                CNT_W    = $clog2(ITERATIONS) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ITERATIONS - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RUN     = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Grant and pointer encoding: 0 selects requester A, 1 selects requester B.
  state_e           state_q,      state_d;
  logic             ptr_q,        ptr_d;
  logic             grant_q,      grant_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [WIDTH-1:0] core_angle_q, core_angle_d;
  logic             core_start_q, core_start_d;
  logic             busy_q,       busy_d;
  logic [WIDTH-1:0] sin_q,        sin_d;
  logic [WIDTH-1:0] cos_q,        cos_d;
  logic             done_a_q,     done_a_d;
  logic             done_b_q,     done_b_d;

  logic             grant_b_s;

  // Round-robin pick: B wins when it is alone, or when both request and the
  // pointer favours B; every other requesting case goes to A.
  always_comb begin
    grant_b_s = req_b_i & (~req_a_i | ptr_q);
  end

  // Next-state and next-output logic. The outputs are computed for the state
  // being entered so that every output leaves a flop.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    core_angle_d = core_angle_q;
    core_start_d = core_start_q;
    busy_d       = busy_q;
    sin_d        = sin_q;
    cos_d        = cos_q;
    done_a_d     = 1'b0;
    done_b_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Requests are looked at only here; anything raised later waits.
        if (req_a_i || req_b_i) begin
          state_d      = ST_LOAD;
          grant_d      = grant_b_s;
          core_angle_d = grant_b_s ? angle_b_i : angle_a_i;
          busy_d       = 1'b1;
          core_start_d = 1'b0;
        end else begin
          state_d      = ST_IDLE;
          busy_d       = 1'b0;
          core_start_d = 1'b0;
        end
      end

      ST_LOAD: begin
        // The single LOAD cycle keeps the core cleared; iteration starts next.
        state_d      = ST_RUN;
        cnt_d        = CNT_ZERO;
        core_start_d = 1'b1;
        busy_d       = 1'b1;
      end

      ST_RUN: begin
        core_start_d = 1'b1;
        busy_d       = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_CAPTURE;
        end else begin
          state_d = ST_RUN;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end

      ST_CAPTURE: begin
        // The core is still enabled in this cycle, so its outputs are stable
        // while they are sampled.
        sin_d        = core_sin_i;
        cos_d        = core_cos_i;
        state_d      = ST_DONE;
        core_start_d = 1'b0;
        busy_d       = 1'b1;
        done_a_d     = ~grant_q;
        done_b_d     = grant_q;
      end

      ST_DONE: begin
        // Hand priority to whoever was not served.
        ptr_d        = ~grant_q;
        cnt_d        = CNT_ZERO;
        state_d      = ST_IDLE;
        core_start_d = 1'b0;
        busy_d       = 1'b0;
      end

      default: begin
        state_d      = ST_IDLE;
        cnt_d        = CNT_ZERO;
        core_start_d = 1'b0;
        busy_d       = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      ptr_q        <= 1'b0;
      grant_q      <= 1'b0;
      cnt_q        <= CNT_ZERO;
      core_angle_q <= '0;
      core_start_q <= 1'b0;
      busy_q       <= 1'b0;
      sin_q        <= '0;
      cos_q        <= '0;
      done_a_q     <= 1'b0;
      done_b_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      core_angle_q <= core_angle_d;
      core_start_q <= core_start_d;
      busy_q       <= busy_d;
      sin_q        <= sin_d;
      cos_q        <= cos_d;
      done_a_q     <= done_a_d;
      done_b_q     <= done_b_d;
    end
  end

  assign done_a_o     = done_a_q;
  assign done_b_o     = done_b_q;
  assign sin_out_o    = sin_q;
  assign cos_out_o    = cos_q;
  assign busy_o       = busy_q;
  assign core_angle_o = core_angle_q;
  assign core_start_o = core_start_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cordic_arbiter
// Directed bench for cordic_arbiter (ITERATIONS=8, WIDTH=8). The CORDIC core is
// stood in for by two bench-driven buses that change value every cycle, so a
// capture on the wrong cycle shows up as a wrong SIN/COS value.
// Cycle k of an operation is the cycle that follows k rising edges after the
// cycle in which IDLE samples the request (cycle 0).
// -----------------------------------------------------------------------------
module tb_cordic_arbiter;

  logic       clk_s = 1'b0;
  logic       rst_n_s;
  logic       req_a_s, req_b_s;
  logic [7:0] angle_a_s, angle_b_s;
  logic       done_a_s, done_b_s;
  logic [7:0] sin_out_s, cos_out_s;
  logic       busy_s;
  logic [7:0] core_angle_s;
  logic       core_start_s;
  logic [7:0] core_sin_s, core_cos_s;

  int n_tests = 0;
  int n_fail  = 0;

  cordic_arbiter #(.ITERATIONS(8), .WIDTH(8)) dut (
    .clk_i       (clk_s),
    .rst_n_i     (rst_n_s),
    .req_a_i     (req_a_s),
    .req_b_i     (req_b_s),
    .angle_a_i   (angle_a_s),
    .angle_b_i   (angle_b_s),
    .done_a_o    (done_a_s),
    .done_b_o    (done_b_s),
    .sin_out_o   (sin_out_s),
    .cos_out_o   (cos_out_s),
    .busy_o      (busy_s),
    .core_angle_o(core_angle_s),
    .core_start_o(core_start_s),
    .core_sin_i  (core_sin_s),
    .core_cos_i  (core_cos_s)
  );

  // 10 ns clock.
  always #5 clk_s = ~clk_s;

  // Count one comparison and report it if it does not match.
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one cycle; new inputs and samples happen 1 ns after the edge.
  // The stand-in core outputs step every cycle.
  task automatic tick();
    @(posedge clk_s);
    #1;
    core_sin_s = core_sin_s + 8'd7;
    core_cos_s = core_cos_s - 8'd5;
  endtask

  // Two reset cycles, then check the reset state and release reset.
  task automatic do_reset();
    rst_n_s = 1'b0;
    req_a_s = 1'b0;
    req_b_s = 1'b0;
    tick();
    tick();
    check_eq("rst_busy",   busy_s,       32'd0);
    check_eq("rst_start",  core_start_s, 32'd0);
    check_eq("rst_angle",  core_angle_s, 32'd0);
    check_eq("rst_sin",    sin_out_s,    32'd0);
    check_eq("rst_cos",    cos_out_s,    32'd0);
    check_eq("rst_done_a", done_a_s,     32'd0);
    check_eq("rst_done_b", done_b_s,     32'd0);
    rst_n_s = 1'b1;
  endtask

  // Called in cycle 0 with the requests already applied. Walks cycles 1..11
  // and returns in cycle 11 (the DONE cycle). If drop_at is nonzero, REQ_A is
  // dropped and ANGLE_A changed to 17 in that cycle.
  task automatic serve(input bit exp_b, input logic [7:0] exp_angle, input int drop_at);
    logic [7:0] snap_sin, snap_cos;
    snap_sin = 8'd0;
    snap_cos = 8'd0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == drop_at) begin
        req_a_s   = 1'b0;
        angle_a_s = 8'd17;
      end
      check_eq("busy",   busy_s,       32'd1);
      check_eq("start",  core_start_s, (k >= 2 && k <= 10) ? 32'd1 : 32'd0);
      check_eq("angle",  core_angle_s, {24'd0, exp_angle});
      check_eq("done_a", done_a_s,     (k == 11 && !exp_b) ? 32'd1 : 32'd0);
      check_eq("done_b", done_b_s,     (k == 11 &&  exp_b) ? 32'd1 : 32'd0);
      if (k == 10) begin
        snap_sin = core_sin_s;
        snap_cos = core_cos_s;
      end
      if (k == 11) begin
        check_eq("sin_out", sin_out_s, {24'd0, snap_sin});
        check_eq("cos_out", cos_out_s, {24'd0, snap_cos});
      end
    end
  endtask

  // One IDLE cycle between operations: nothing busy, core held cleared.
  task automatic idle_gap(input string tag);
    tick();
    check_eq({tag, "_busy"},   busy_s,       32'd0);
    check_eq({tag, "_start"},  core_start_s, 32'd0);
    check_eq({tag, "_done_a"}, done_a_s,     32'd0);
    check_eq({tag, "_done_b"}, done_b_s,     32'd0);
  endtask

  initial begin
    rst_n_s    = 1'b0;
    req_a_s    = 1'b0;
    req_b_s    = 1'b0;
    angle_a_s  = 8'd0;
    angle_b_s  = 8'd0;
    core_sin_s = 8'd3;
    core_cos_s = 8'd200;

    // Single A request, angle 210.
    do_reset();
    req_a_s   = 1'b1;
    angle_a_s = 8'd210;
    serve(1'b0, 8'd210, 0);
    req_a_s = 1'b0;
    idle_gap("single_gap");
    idle_gap("single_quiet");

    // Both requesting from reset: A first, then B (pointer moved to B),
    // then A again (pointer back to A).
    do_reset();
    req_a_s   = 1'b1;
    req_b_s   = 1'b1;
    angle_a_s = 8'd210;
    angle_b_s = 8'd94;
    serve(1'b0, 8'd210, 0);
    idle_gap("both_gap1");
    serve(1'b1, 8'd94, 0);
    idle_gap("both_gap2");
    serve(1'b0, 8'd210, 0);
    req_a_s = 1'b0;
    req_b_s = 1'b0;

    // B alone, then A and B together: A wins.
    do_reset();
    req_b_s   = 1'b1;
    angle_b_s = 8'd94;
    serve(1'b1, 8'd94, 0);
    req_a_s = 1'b1;
    idle_gap("rr_gap");
    serve(1'b0, 8'd210, 0);
    req_a_s = 1'b0;
    req_b_s = 1'b0;

    // Reset during RUN after A was served (pointer at B): abort with no DONE,
    // then both requesting must go to A because reset put the pointer at A.
    do_reset();
    req_a_s   = 1'b1;
    angle_a_s = 8'd210;
    serve(1'b0, 8'd210, 0);
    idle_gap("abort_pre");
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_eq("abort_run_done_a", done_a_s, 32'd0);
    end
    rst_n_s = 1'b0;
    req_a_s = 1'b0;
    tick();
    check_eq("abort_start",  core_start_s, 32'd0);
    check_eq("abort_busy",   busy_s,       32'd0);
    check_eq("abort_done_a", done_a_s,     32'd0);
    check_eq("abort_done_b", done_b_s,     32'd0);
    check_eq("abort_angle",  core_angle_s, 32'd0);
    rst_n_s   = 1'b1;
    req_a_s   = 1'b1;
    req_b_s   = 1'b1;
    angle_a_s = 8'd210;
    angle_b_s = 8'd94;
    serve(1'b0, 8'd210, 0);
    req_a_s = 1'b0;
    req_b_s = 1'b0;

    // REQ_A dropped at cycle 4 with ANGLE_A changed: operation completes.
    do_reset();
    req_a_s   = 1'b1;
    angle_a_s = 8'd210;
    serve(1'b0, 8'd210, 4);
    idle_gap("drop_gap");
    idle_gap("drop_quiet");

    // Continuous B: DONE_B every 12 cycles, one idle cycle between.
    do_reset();
    req_b_s   = 1'b1;
    angle_b_s = 8'd94;
    serve(1'b1, 8'd94, 0);
    idle_gap("cont_gap1");
    serve(1'b1, 8'd94, 0);
    idle_gap("cont_gap2");
    serve(1'b1, 8'd94, 0);
    req_b_s = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
